// File: rtl/sdio_cis_reader_if.sv
// sdio_cis_reader_if
// Bundles every signal of the CIS burst reader except clock and reset.
// The reader connects through the slave modport. The master modport is the
// environment's view: CIA command decoder, CIS ROM port and stream consumer.
//   request side : i_req_stb, i_req_addr[17:0], i_req_count[8:0], i_abort,
//                  o_busy, o_done
//   ROM side     : o_cis_activate, o_cis_address[17:0], o_cis_data_stb,
//                  i_cis_data[7:0]
//   stream side  : o_rd_data[7:0], o_rd_valid, i_rd_ready
interface sdio_cis_reader_if;
  logic        i_req_stb;
  logic [17:0] i_req_addr;
  logic [8:0]  i_req_count;
  logic        i_abort;
  logic        o_busy;
  logic        o_done;
  logic        o_cis_activate;
  logic [17:0] o_cis_address;
  logic        o_cis_data_stb;
  logic [7:0]  i_cis_data;
  logic [7:0]  o_rd_data;
  logic        o_rd_valid;
  logic        i_rd_ready;

  modport slave (
    input  i_req_stb, i_req_addr, i_req_count, i_abort, i_cis_data, i_rd_ready,
    output o_busy, o_done, o_cis_activate, o_cis_address, o_cis_data_stb,
           o_rd_data, o_rd_valid
  );

  modport master (
    output i_req_stb, i_req_addr, i_req_count, i_abort, i_cis_data, i_rd_ready,
    input  o_busy, o_done, o_cis_activate, o_cis_address, o_cis_data_stb,
           o_rd_data, o_rd_valid
  );
endinterface

// File: rtl/sdio_cis_reader.sv
// sdio_cis_reader
// Burst reader for the function-0 CIS ROM. It takes a start address and a
// byte count (0 means 512) and issues pipelined ROM strobes. Returned bytes
// go into a 4-entry FIFO, which is presented as a valid/ready byte stream.
// Ports:
//   clk  system clock
//   rst  asynchronous active-high reset
//   bus  sdio_cis_reader_if.slave (request, ROM port and stream signals)
// Optional feature macro: SDIO_CIS_TUPLE_STOP_EN. When it is defined, a
// captured 0xFF byte (CISTPL_END) ends the burst early after it is delivered.
module sdio_cis_reader (
  input logic               clk,
  input logic               rst,
  sdio_cis_reader_if.slave  bus
);

  typedef enum logic [1:0] {IDLE, READ, DRAIN, DONE} state_t;

  state_t      state, state_next;
  logic [17:0] addr_q;
  logic [9:0]  remaining_q;
  logic        stb_d1;
  logic [7:0]  fifo_mem [4];
  logic [1:0]  wr_ptr, rd_ptr;
  logic [2:0]  fifo_count, fifo_count_next;
  logic        strobe, push, pop, rd_valid, tuple_end;

  // A byte arrives the cycle after its strobe. During an abort that byte
  // belongs to the cancelled transfer, so it is dropped.
  assign push     = stb_d1 && !bus.i_abort;
  assign rd_valid = (fifo_count != 3'd0);
  assign pop      = rd_valid && bus.i_rd_ready;
  assign fifo_count_next = fifo_count + {2'b00, push} - {2'b00, pop};

`ifdef SDIO_CIS_TUPLE_STOP_EN
  // The end tuple is seen as it is captured. Suppressing the strobe in the
  // same cycle means no byte from beyond 0xFF is ever requested.
  assign tuple_end = push && (state == READ) && (bus.i_cis_data == 8'hFF);
`else
  assign tuple_end = 1'b0;
`endif

  // Strobe only while bytes remain. Bytes already in the FIFO plus the one
  // in flight must leave room, so three slots are the worst-case fill even
  // with the consumer stalled.
  assign strobe = (state == READ) && !bus.i_abort && !tuple_end &&
                  (remaining_q != 10'd0) &&
                  ((fifo_count + {2'b00, stb_d1}) <= 3'd2);

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  // Next-state logic. DRAIN looks at the FIFO count after this cycle's pop.
  // This lets o_done land in the cycle right after the final handshake.
  // Abort overrides everything and also drops a coincident request.
  always_comb begin
    state_next = state;
    case (state)
      IDLE:  if (bus.i_req_stb) state_next = READ;
      READ:  if (tuple_end || remaining_q == 10'd0 ||
                 (strobe && remaining_q == 10'd1)) state_next = DRAIN;
      DRAIN: if (!stb_d1 && fifo_count_next == 3'd0) state_next = DONE;
      DONE:  state_next = IDLE;
      default: state_next = IDLE;
    endcase
    if (bus.i_abort) state_next = IDLE;
  end

  // Address, remaining count and strobe pipeline. The address wraps at 18
  // bits on its own. Abort clears the count and the in-flight marker.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      addr_q      <= '0;
      remaining_q <= '0;
      stb_d1      <= 1'b0;
    end else if (bus.i_abort) begin
      remaining_q <= '0;
      stb_d1      <= 1'b0;
    end else begin
      stb_d1 <= strobe;
      if (state == IDLE && bus.i_req_stb) begin
        addr_q      <= bus.i_req_addr;
        remaining_q <= (bus.i_req_count == 9'd0) ? 10'd512 : {1'b0, bus.i_req_count};
      end else if (tuple_end) begin
        remaining_q <= '0;
      end else if (strobe) begin
        addr_q      <= addr_q + 18'd1;
        remaining_q <= remaining_q - 10'd1;
      end
    end
  end

  // FIFO pointers and occupancy. A push and a pop in the same cycle leave
  // the count unchanged. Each pointer moves independently, so order holds.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_count <= '0;
    end else if (bus.i_abort) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_count <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 2'd1;
      if (pop)  rd_ptr <= rd_ptr + 2'd1;
      fifo_count <= fifo_count_next;
    end
  end

  // FIFO storage. It is cleared on reset so the stream byte reads 0x00.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < 4; i++) fifo_mem[i] <= 8'h00;
    end else if (push) begin
      fifo_mem[wr_ptr] <= bus.i_cis_data;
    end
  end

  // Moore-style outputs decoded from the state and the datapath registers.
  always_comb begin
    bus.o_busy         = (state != IDLE);
    bus.o_done         = (state == DONE);
    bus.o_cis_activate = (state == READ) || (state == DRAIN);
    bus.o_cis_data_stb = strobe;
    bus.o_cis_address  = addr_q;
    bus.o_rd_data      = fifo_mem[rd_ptr];
    bus.o_rd_valid     = rd_valid;
  end

endmodule

// File: tb/tb_sdio_cis_reader.sv
// tb_sdio_cis_reader
// Self-checking bench for sdio_cis_reader. It models a registered 256-byte
// CIS ROM (mirrored by the low address byte) and logs stream handshakes,
// ROM strobes and done pulses at the falling edge. Expected bytes come from
// the bench ROM table, and expected cycles are hand-derived constants.
// Build with SDIO_CIS_TUPLE_STOP_EN defined to check the end-tuple variant.
module tb_sdio_cis_reader;
  logic clk = 1'b0;
  logic rst = 1'b1;

  sdio_cis_reader_if bus();

  sdio_cis_reader dut (.clk(clk), .rst(rst), .bus(bus));

  always #5 clk = ~clk;

  typedef struct {
    logic [17:0] addr;
    logic [8:0]  count;
    int          expBytes;
    int          expDone;
  } burst_vec_t;

  burst_vec_t  vecs [5];
  int          vecCount = 0;
  int          missCount = 0;
  int          cyc = 0;
  int          startCyc = 0;
  int          doneCount = 0;
  int          doneCyc = -1;
  logic [7:0]  romMem [256];
  logic [7:0]  gotData [$];
  int          gotCyc [$];
  logic [17:0] stbAddr [$];

  // Cycle counter; cycle 0 of a burst is the cycle the request is high.
  always @(posedge clk) cyc++;

  // Registered ROM: data appears the cycle after a strobe.
  always @(posedge clk or posedge rst) begin
    if (rst) bus.i_cis_data <= 8'h00;
    else if (bus.o_cis_data_stb) bus.i_cis_data <= romMem[bus.o_cis_address[7:0]];
  end

  // Falling-edge monitor for handshakes, strobes and done pulses.
  always @(negedge clk) begin
    if (!rst) begin
      if (bus.o_rd_valid && bus.i_rd_ready) begin
        gotData.push_back(bus.o_rd_data);
        gotCyc.push_back(cyc - startCyc);
      end
      if (bus.o_cis_data_stb) stbAddr.push_back(bus.o_cis_address);
      if (bus.o_done) begin
        doneCount++;
        doneCyc = cyc - startCyc;
      end
    end
  end

  task automatic checkOutput(input string name, input longint actual, input longint expected);
    vecCount++;
    if (actual !== expected) begin
      missCount++;
      $display("[TB] FAIL %s: actual=%0h expected=%0h", name, actual, expected);
    end
  endtask

  task automatic applyStimulus(input logic [17:0] addr, input logic [8:0] count);
    @(posedge clk); #1;
    gotData.delete(); gotCyc.delete(); stbAddr.delete();
    doneCount = 0; doneCyc = -1;
    bus.i_req_addr = addr; bus.i_req_count = count; bus.i_req_stb = 1'b1;
    startCyc = cyc;
    @(posedge clk); #1;
    bus.i_req_stb = 1'b0;
  endtask

  task automatic waitIdle(input int budget, output int lowCyc);
    bit seen = 1'b0;
    lowCyc = -1;
    for (int i = 0; i < budget && !seen; i++) begin
      @(posedge clk); #1;
      if (!bus.o_busy) begin
        seen = 1'b1;
        lowCyc = cyc - startCyc;
      end
    end
  endtask

  task automatic checkBurst(input string tag, input logic [17:0] addr, input int expBytes,
                            input int expDone, input int lowCyc, input bit withTiming);
    int badData = 0;
    int badAddr = 0;
    checkOutput({tag, " bytes"}, gotData.size(), expBytes);
    checkOutput({tag, " strobes"}, stbAddr.size(), expBytes);
    for (int i = 0; i < gotData.size(); i++) begin
      logic [17:0] a = addr + 18'(i);
      if (gotData[i] !== romMem[a[7:0]]) badData++;
    end
    for (int i = 0; i < stbAddr.size(); i++) begin
      logic [17:0] a = addr + 18'(i);
      if (stbAddr[i] !== a) badAddr++;
    end
    checkOutput({tag, " data_errs"}, badData, 0);
    checkOutput({tag, " addr_errs"}, badAddr, 0);
    checkOutput({tag, " done_pulses"}, doneCount, 1);
    if (withTiming) begin
      checkOutput({tag, " first_cycle"}, gotCyc[0], 3);
      checkOutput({tag, " done_cycle"}, doneCyc, expDone);
      checkOutput({tag, " busy_low_cycle"}, lowCyc, expDone + 1);
    end
  endtask

  initial begin
    int lowCyc;
    bit hit;

    bus.i_req_stb = 1'b0; bus.i_req_addr = '0; bus.i_req_count = '0;
    bus.i_abort = 1'b0; bus.i_rd_ready = 1'b1;
    for (int i = 0; i < 256; i++) romMem[i] = 8'(i & 127);
    romMem[0] = 8'h01; romMem[1] = 8'h03; romMem[2] = 8'hD9; romMem[3] = 8'h01;

    vecs[0] = '{18'h00000, 9'd4, 4, 7};
    vecs[1] = '{18'h00010, 9'd1, 1, 4};
    vecs[2] = '{18'h3FFFE, 9'd3, 3, 6};
    vecs[3] = '{18'h3FFFE, 9'd0, 512, 515};
    vecs[4] = '{18'h12345, 9'd9, 9, 12};

    // Reset state.
    repeat (2) @(posedge clk); #1;
    checkOutput("reset_outputs", {bus.o_busy, bus.o_done, bus.o_cis_activate, bus.o_cis_address,
                bus.o_cis_data_stb, bus.o_rd_data, bus.o_rd_valid}, 0);
    @(negedge clk) rst = 1'b0;

    // Table-driven bursts with the consumer always ready.
    for (int v = 0; v < 5; v++) begin
      applyStimulus(vecs[v].addr, vecs[v].count);
      waitIdle(700, lowCyc);
      checkBurst($sformatf("vec%0d", v), vecs[v].addr, vecs[v].expBytes, vecs[v].expDone, lowCyc, 1'b1);
    end

    // Basic burst against the literal ROM bytes and handshake cycles.
    applyStimulus(18'h0, 9'd4);
    waitIdle(50, lowCyc);
    checkOutput("basic_stream", {gotData[0], gotData[1], gotData[2], gotData[3]}, 32'h0103D901);
    checkOutput("basic_last_cycle", gotCyc[3], 6);

    // Backpressure: consumer stalled for 10 cycles after the first valid.
    bus.i_rd_ready = 1'b0;
    applyStimulus(18'h00040, 9'd8);
    hit = 1'b0;
    for (int i = 0; i < 20 && !hit; i++) begin
      if (bus.o_rd_valid) hit = 1'b1;
      else begin @(posedge clk); #1; end
    end
    checkOutput("bp_first_valid_cycle", cyc - startCyc, 3);
    repeat (10) @(posedge clk);
    #1;
    checkOutput("bp_strobes_while_stalled", stbAddr.size(), 3);
    checkOutput("bp_valid_held", bus.o_rd_valid, 1);
    bus.i_rd_ready = 1'b1;
    waitIdle(100, lowCyc);
    checkBurst("bp", 18'h00040, 8, 0, lowCyc, 1'b0);

    // Abort after the second handshake, then restart at address 0.
    applyStimulus(18'h0, 9'd8);
    hit = 1'b0;
    for (int i = 0; i < 20 && !hit; i++) begin
      if (gotData.size() >= 2) hit = 1'b1;
      else begin @(posedge clk); #1; end
    end
    bus.i_abort = 1'b1;
    @(posedge clk); #1;
    bus.i_abort = 1'b0;
    checkOutput("abort_valid_low", bus.o_rd_valid, 0);
    checkOutput("abort_busy_low", bus.o_busy, 0);
    repeat (5) @(posedge clk);
    #1;
    checkOutput("abort_no_done", doneCount, 0);
    applyStimulus(18'h0, 9'd2);
    waitIdle(50, lowCyc);
    checkOutput("abort_restart_first", gotData[0], 8'h01);
    checkBurst("restart", 18'h0, 2, 5, lowCyc, 1'b1);

    // Asynchronous reset in the middle of a burst.
    applyStimulus(18'h00080, 9'd16);
    repeat (3) @(posedge clk);
    @(negedge clk); #2;
    rst = 1'b1;
    #1;
    checkOutput("midreset_outputs", {bus.o_busy, bus.o_done, bus.o_cis_activate, bus.o_cis_address,
                bus.o_cis_data_stb, bus.o_rd_data, bus.o_rd_valid}, 0);
    @(negedge clk) rst = 1'b0;
    @(posedge clk); #1;
    checkOutput("midreset_idle_busy", bus.o_busy, 0);

    // End tuple in the data.
    romMem[8'h20] = 8'h20; romMem[8'h21] = 8'h02; romMem[8'h22] = 8'hFF; romMem[8'h23] = 8'h55;
    applyStimulus(18'h00020, 9'd4);
    waitIdle(50, lowCyc);
    checkOutput("tuple_third_byte", gotData[2], 8'hFF);
`ifdef SDIO_CIS_TUPLE_STOP_EN
    checkBurst("tuple", 18'h00020, 3, 6, lowCyc, 1'b1);
`else
    checkBurst("tuple", 18'h00020, 4, 7, lowCyc, 1'b1);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vecCount, missCount);
    $finish;
  end

  // Overall time guard so the run always ends.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: actual=timeout required=finish");
    $fatal(1, "[TB] watchdog expired");
  end
endmodule
